// File: rtl/axi_req_fifo.sv
// AXI AR/AW request FIFO with first-word fall-through and an optional output register stage (PIPE_OUT).
// Define AXI_REQ_FIFO_HWM_EN to add the hwm high-water-mark output.
module axi_req_fifo #(
  parameter  int ADDR_WIDTH   = 32,
  parameter  int ID_WIDTH     = 4,
  parameter  int DEPTH        = 8,
  parameter  int AFULL_THRESH = DEPTH - 2,
  parameter  int PIPE_OUT     = 0,
  localparam int CAP          = DEPTH + PIPE_OUT,
  localparam int CW           = $clog2(CAP + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [ID_WIDTH-1:0]   push_id,
  input  logic [1:0]            push_burst,
  input  logic [2:0]            push_size,
  input  logic [7:0]            push_len,
  input  logic                  push_valid,
  output logic                  push_ready,
  output logic [ADDR_WIDTH-1:0] pop_addr,
  output logic [ID_WIDTH-1:0]   pop_id,
  output logic [1:0]            pop_burst,
  output logic [2:0]            pop_size,
  output logic [7:0]            pop_len,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
`ifdef AXI_REQ_FIFO_HWM_EN
  ,
  output logic [CW-1:0]         hwm
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = ADDR_WIDTH + ID_WIDTH + 13;
  localparam logic [CW-1:0] CAP_C   = CW'(CAP);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [DW-1:0] w_push_data;
  logic [DW-1:0] w_pop_data;
  logic          w_push;
  logic          w_pop;
  logic          w_mem_rd;
  logic          w_pop_valid;

  assign w_push_data = {push_addr, push_id, push_burst, push_size, push_len};
  assign push_ready  = !full && !flush && !rst;
  assign w_push      = push_valid && push_ready;
  assign w_pop       = w_pop_valid && pop_ready;

  // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_mem_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked solely by count and pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  if (PIPE_OUT != 0) begin : g_pipe
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          w_mem_has;

    // Memory holds count minus the output-stage entry.
    assign w_mem_has = (r_count != CW'(r_out_valid));
    assign w_mem_rd  = w_mem_has && (!r_out_valid || w_pop);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_mem_rd) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem[r_rd_ptr];
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end

    assign w_pop_valid = r_out_valid;
    assign w_pop_data  = r_out_data;
  end else begin : g_comb
    assign w_mem_rd    = w_pop;
    assign w_pop_valid = (r_count != '0);
    assign w_pop_data  = r_mem[r_rd_ptr];
  end

  assign pop_valid = w_pop_valid;
  assign {pop_addr, pop_id, pop_burst, pop_size, pop_len} = w_pop_data;
  assign count       = r_count;
  assign full        = (r_count == CAP_C);
  assign empty       = (r_count == '0);
  assign almost_full = (r_count >= AFULL_C);

`ifdef AXI_REQ_FIFO_HWM_EN
  logic [CW-1:0] r_hwm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hwm <= '0;
    end else if (flush) begin
      r_hwm <= '0;
    end else if (w_count_nxt > r_hwm) begin
      r_hwm <= w_count_nxt;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_axi_req_fifo.sv
// Self-checking bench: DUT 0 is DEPTH=8/PIPE_OUT=0, DUT 1 is DEPTH=4/PIPE_OUT=1, both checked against a queue model.
module tb_axi_req_fifo;

  typedef logic [48:0] req_t;
  typedef struct {
    req_t data;
    int   p;
  } ent_t;

  localparam int CAP_M  [2] = '{8, 5};
  localparam int PIPE_M [2] = '{0, 1};
  localparam int AF_M   [2] = '{6, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic        flush      [2];
  logic        push_valid [2];
  logic        push_ready [2];
  logic [31:0] push_addr  [2];
  logic [3:0]  push_id    [2];
  logic [1:0]  push_burst [2];
  logic [2:0]  push_size  [2];
  logic [7:0]  push_len   [2];
  logic        pop_valid  [2];
  logic        pop_ready  [2];
  logic [31:0] pop_addr   [2];
  logic [3:0]  pop_id     [2];
  logic [1:0]  pop_burst  [2];
  logic [2:0]  pop_size   [2];
  logic [7:0]  pop_len    [2];
  logic        full       [2];
  logic        empty      [2];
  logic        afull      [2];
  logic [3:0]  a_count;
  logic [2:0]  b_count;
`ifdef AXI_REQ_FIFO_HWM_EN
  logic [3:0]  a_hwm;
  logic [2:0]  b_hwm;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mh    [2];
  bit   acc_push [2];
  bit   acc_pop  [2];
  req_t acc_data [2];
  ent_t q0 [$];
  ent_t q1 [$];

  always #5 clk = ~clk;

  axi_req_fifo #(.DEPTH(8), .PIPE_OUT(0)) u_a (
    .clk(clk), .rst(rst), .flush(flush[0]),
    .push_addr(push_addr[0]), .push_id(push_id[0]), .push_burst(push_burst[0]),
    .push_size(push_size[0]), .push_len(push_len[0]),
    .push_valid(push_valid[0]), .push_ready(push_ready[0]),
    .pop_addr(pop_addr[0]), .pop_id(pop_id[0]), .pop_burst(pop_burst[0]),
    .pop_size(pop_size[0]), .pop_len(pop_len[0]),
    .pop_valid(pop_valid[0]), .pop_ready(pop_ready[0]),
    .count(a_count), .full(full[0]), .empty(empty[0]), .almost_full(afull[0])
`ifdef AXI_REQ_FIFO_HWM_EN
    , .hwm(a_hwm)
`endif
  );

  axi_req_fifo #(.DEPTH(4), .PIPE_OUT(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush[1]),
    .push_addr(push_addr[1]), .push_id(push_id[1]), .push_burst(push_burst[1]),
    .push_size(push_size[1]), .push_len(push_len[1]),
    .push_valid(push_valid[1]), .push_ready(push_ready[1]),
    .pop_addr(pop_addr[1]), .pop_id(pop_id[1]), .pop_burst(pop_burst[1]),
    .pop_size(pop_size[1]), .pop_len(pop_len[1]),
    .pop_valid(pop_valid[1]), .pop_ready(pop_ready[1]),
    .count(b_count), .full(full[1]), .empty(empty[1]), .almost_full(afull[1])
`ifdef AXI_REQ_FIFO_HWM_EN
    , .hwm(b_hwm)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cnt(input int k);
    return (k == 0) ? 64'(a_count) : 64'(b_count);
  endfunction

`ifdef AXI_REQ_FIFO_HWM_EN
  function automatic logic [63:0] hwm_of(input int k);
    return (k == 0) ? 64'(a_hwm) : 64'(b_hwm);
  endfunction
`endif

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ent_t qhead(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  // Head is visible once PIPE_OUT edges have passed since it was accepted.
  function automatic bit vis_exp(input int k);
    ent_t h;
    if (qsize(k) == 0) return 1'b0;
    h = qhead(k);
    return cyc >= h.p + PIPE_M[k];
  endfunction

  function automatic req_t in_data(input int k);
    return {push_addr[k], push_id[k], push_burst[k], push_size[k], push_len[k]};
  endfunction

  function automatic logic [63:0] out_data(input int k);
    return 64'({pop_addr[k], pop_id[k], pop_burst[k], pop_size[k], pop_len[k]});
  endfunction

  task automatic set_in(input int k, input bit pv, input logic [31:0] addr, input logic [3:0] id,
                        input bit pr, input bit fl);
    push_valid[k] = pv;
    push_addr[k]  = addr;
    push_id[k]    = id;
    push_burst[k] = addr[1:0];
    push_size[k]  = addr[4:2];
    push_len[k]   = addr[12:5];
    pop_ready[k]  = pr;
    flush[k]      = fl;
  endtask

  task automatic check_outputs(input int k);
    int n;
    n = qsize(k);
    check($sformatf("dut%0d count", k), cnt(k), 64'(n));
    check($sformatf("dut%0d full", k), 64'(full[k]), 64'(n == CAP_M[k]));
    check($sformatf("dut%0d empty", k), 64'(empty[k]), 64'(n == 0));
    check($sformatf("dut%0d almost_full", k), 64'(afull[k]), 64'(n >= AF_M[k]));
    check($sformatf("dut%0d push_ready", k), 64'(push_ready[k]),
          64'(!flush[k] && !rst && n < CAP_M[k]));
    check($sformatf("dut%0d pop_valid", k), 64'(pop_valid[k]), 64'(vis_exp(k)));
    if (vis_exp(k)) check($sformatf("dut%0d pop_data", k), out_data(k), 64'(qhead(k).data));
`ifdef AXI_REQ_FIFO_HWM_EN
    check($sformatf("dut%0d hwm", k), hwm_of(k), 64'(mh[k]));
`endif
  endtask

  task automatic model_edge(input int k);
    ent_t e;
    if (flush[k]) begin
      if (k == 0) q0.delete(); else q1.delete();
      mh[k] = 0;
    end else begin
      if (acc_pop[k]) begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (acc_push[k]) begin
        e.data = acc_data[k];
        e.p    = cyc;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (qsize(k) > mh[k]) mh[k] = qsize(k);
    end
  endtask

  // One clock: check settled outputs, predict handshakes, take the edge, advance the model.
  task automatic cycle();
    #1;
    for (int k = 0; k < 2; k++) begin
      check_outputs(k);
      acc_push[k] = push_valid[k] && !flush[k] && qsize(k) < CAP_M[k];
      acc_pop[k]  = pop_ready[k] && vis_exp(k);
      acc_data[k] = in_data(k);
    end
    @(posedge clk);
    #2;
    cyc++;
    for (int k = 0; k < 2; k++) model_edge(k);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    mh[0] = 0;
    mh[1] = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_outputs(k);
      check($sformatf("dut%0d rst pop_valid", k), 64'(pop_valid[k]), 64'd0);
      check($sformatf("dut%0d rst count", k), cnt(k), 64'd0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord [2];
    for (int k = 0; k < 2; k++) set_in(k, 0, 0, 0, 0, 0);

    // Reset state, then push_ready on the first cycle after release.
    do_reset();
    cycle();

    // Fill both with pop_ready low: DUT 0 to 8 entries, DUT 1 saturates at 5.
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 32'h100 + i, 4'(i), 0, 0);
      set_in(1, 1, 32'h200 + i, 4'(i), 0, 0);
      cycle();
      check("fill almost_full", 64'(afull[0]), 64'((i + 1) >= 6));
    end
    for (int k = 0; k < 2; k++) set_in(k, 0, 0, 0, 0, 0);
    #1;
    check("fill8 count", cnt(0), 64'd8);
    check("fill8 full", 64'(full[0]), 64'd1);
    check("fill8 push_ready", 64'(push_ready[0]), 64'd0);
    check("fill8 head addr", 64'(pop_addr[0]), 64'h100);
    check("pipe fill count", cnt(1), 64'd5);
    check("pipe fill full", 64'(full[1]), 64'd1);
`ifdef AXI_REQ_FIFO_HWM_EN
    check("pipe fill hwm", hwm_of(1), 64'd5);
`endif
    for (int k = 0; k < 2; k++) set_in(k, 0, 0, 0, 1, 0);
    for (int j = 0; j < 12; j++) cycle();

    // Latency from push into an empty FIFO to pop_valid.
    for (int k = 0; k < 2; k++) set_in(k, 1, 32'h3C0, 4'd3, 0, 0);
    cycle();
    for (int k = 0; k < 2; k++) set_in(k, 0, 0, 0, 0, 0);
    check("lat pipe0 valid at N+1", 64'(pop_valid[0]), 64'd1);
    check("lat pipe0 id", 64'(pop_id[0]), 64'd3);
    check("lat pipe1 not valid at N+1", 64'(pop_valid[1]), 64'd0);
    cycle();
    check("lat pipe1 valid at N+2", 64'(pop_valid[1]), 64'd1);
    check("lat pipe1 id", 64'(pop_id[1]), 64'd3);
    for (int k = 0; k < 2; k++) set_in(k, 0, 0, 0, 1, 0);
    for (int j = 0; j < 3; j++) cycle();

    // Streaming 20 entries with pop_ready high; order must survive pointer wrap.
    ord[0] = 0;
    ord[1] = 0;
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 2; k++) set_in(k, i < 20, 32'(i), 4'(i), 1, 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (pop_valid[k]) begin
          check($sformatf("dut%0d stream order", k), 64'(pop_addr[k]), 64'(ord[k]));
          ord[k]++;
        end
      end
      cycle();
    end
    check("stream pipe0 popped", 64'(ord[0]), 64'd20);
    check("stream pipe1 popped", 64'(ord[1]), 64'd20);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++)
        set_in(k, $urandom_range(0, 3) != 0, $urandom, 4'($urandom), $urandom_range(0, 2) != 0,
               $urandom_range(0, 40) == 0);
      cycle();
    end

    // Flush with five entries held and a push offered in the same cycle.
    for (int k = 0; k < 2; k++) set_in(k, 0, 0, 0, 1, 0);
    for (int j = 0; j < 10; j++) cycle();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 32'h500 + i, 4'(i), 0, 0);
      set_in(1, 0, 0, 0, 0, 0);
      cycle();
    end
    check("pre-flush count", cnt(0), 64'd5);
    set_in(0, 1, 32'hDEAD, 4'hD, 0, 1);
    cycle();
    set_in(0, 0, 0, 0, 1, 0);
    check("flush count", cnt(0), 64'd0);
    check("flush empty", 64'(empty[0]), 64'd1);
    check("flush pop_valid", 64'(pop_valid[0]), 64'd0);
`ifdef AXI_REQ_FIFO_HWM_EN
    check("flush hwm", hwm_of(0), 64'd0);
`endif
    cycle();
    check("flush entry absent", 64'(pop_valid[0]), 64'd0);

    // Asynchronous reset in the middle of a burst with four entries held.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) set_in(k, 1, 32'h700 + i, 4'(i), 0, 0);
      cycle();
    end
    check("pre-rst count", cnt(0), 64'd4);
    for (int k = 0; k < 2; k++) set_in(k, 0, 0, 0, 0, 0);
    do_reset();
    cycle();
    check("post-rst push_ready dut0", 64'(push_ready[0]), 64'd1);
    check("post-rst push_ready dut1", 64'(push_ready[1]), 64'd1);
    for (int j = 0; j < 2; j++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_req_fifo.md
AXI_REQ_FIFO -- requirements
Module: axi_req_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address field width.
REQ-002 SHALL have parameter ID_WIDTH, default 4, ID field width.
REQ-003 SHALL have parameter DEPTH, default 8, memory entries; power of two, >= 2.
REQ-004 SHALL have parameter AFULL_THRESH, default DEPTH-2, almost_full assert level.
REQ-005 SHALL have parameter PIPE_OUT, default 0, 1 = extra output register stage.
REQ-006 SHALL define CAP = DEPTH+PIPE_OUT and CW = clog2(CAP+1).
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port flush  input  1  synchronous content clear.
REQ-010 SHALL have ports push_addr/push_id/push_burst/push_size/push_len  input  ADDR_WIDTH/ID_WIDTH/2/3/8  AXI AR/AW request fields.
REQ-011 SHALL have ports push_valid  input  1 and push_ready  output  1, push handshake.
REQ-012 SHALL have ports pop_addr/pop_id/pop_burst/pop_size/pop_len  output  same widths  head entry fields.
REQ-013 SHALL have ports pop_valid  output  1 and pop_ready  input  1, pop handshake.
REQ-014 SHALL have ports count  output  CW  entries held; full, empty, almost_full  output  1 each  status.

Function
REQ-015 SHALL accept a push when push_valid && push_ready; pop when pop_valid && pop_ready.
REQ-016 SHALL drive push_ready = !full && !flush; push_ready SHALL NOT depend on pop_ready.
REQ-017 SHALL present head entry on pop_* as first-word fall-through, pop_valid = entry present at head.
REQ-018 SHALL, with PIPE_OUT=0, raise pop_valid the cycle after a push into an empty FIFO (latency 1).
REQ-019 SHALL, with PIPE_OUT=1, raise pop_valid two cycles after a push into an empty FIFO (latency 2), all pop_* driven from flops.
REQ-020 SHALL sustain one push and one pop per cycle in steady state in both PIPE_OUT modes.
REQ-021 SHALL hold pop_* stable while pop_valid && !pop_ready.
REQ-022 SHALL keep count = entries held (memory plus output stage); full = (count == CAP); empty = (count == 0); almost_full = (count >= AFULL_THRESH).
REQ-023 SHALL on simultaneous push and pop leave count unchanged.
REQ-024 SHALL wrap read/write pointers modulo DEPTH without loss or duplication.
REQ-025 SHALL preserve FIFO order across wrap-around and across the output stage.
REQ-026 SHALL on flush set count 0, pointers 0, pop_valid 0 at next edge; push and pop in the flush cycle SHALL be ignored.
REQ-027 SHALL ignore pop_ready while pop_valid is low.

Reset
REQ-028 SHALL on rst asserted immediately force pointers 0, count 0, pop_valid 0, push_ready 0 while rst high, empty 1, full 0, almost_full 0.
REQ-029 SHALL discard all contents on reset mid-operation; memory array SHALL NOT be reset.
REQ-030 SHALL assert push_ready the first cycle after rst deasserts.

Configuration
REQ-031 SHALL, with macro AXI_REQ_FIFO_HWM_EN defined, add port hwm  output  CW  highest count since reset or flush, updated same edge as count, cleared by rst and flush.
REQ-032 SHALL, without AXI_REQ_FIFO_HWM_EN, omit hwm port and logic; all other behaviour identical.

Verification
REQ-033 SHALL cover: DEPTH=8, PIPE_OUT=0, push 8 entries addr 0x100..0x107, pop_ready=0 -> count=8, full=1, push_ready=0, almost_full=1 from count 6.
REQ-034 SHALL cover: push id=3 into empty FIFO at cycle N -> PIPE_OUT=0 pop_valid at N+1; PIPE_OUT=1 pop_valid at N+2, pop_id=3.
REQ-035 SHALL cover: continuous push/pop 20 entries, pop_ready=1 -> count constant, output order 0..19 across pointer wrap.
REQ-036 SHALL cover: count=5, flush=1 with push_valid=1 -> next cycle count=0, empty=1, pushed entry absent; hwm=0 if enabled.
REQ-037 SHALL cover: rst pulse mid-burst with count=4 -> pop_valid=0 and count=0 immediately, push_ready=1 after release.
REQ-038 SHALL cover: PIPE_OUT=1, DEPTH=4, pop_ready=0, push 5 -> full=1 at count=5; hwm=5 if enabled.
